// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio -- 8N1 UART receiver with a small receive FIFO behind a
// read-only memory-mapped register pair.
//
// Ports
//   clk    : single clock, all state on the rising edge
//   rst    : asynchronous reset, active low
//   rx     : asynchronous serial input, idle high, LSB first
//   rEn    : bus read strobe, one access per asserted cycle
//   addr   : bus byte address
//   rData  : read data, combinational from addr and current state
//   rxIrq  : registered "FIFO non-empty", lags the FIFO state by one cycle
//
// Register map
//   0xFFFF_FFF8 DATA   : {24'b0, head byte}, reading with rEn pops the head
//   0xFFFF_FFF4 STATUS : {28'b0, FE, OVR, full, nonEmpty}, reading with rEn
//                        clears FE and OVR
module uart_rx_mmio #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        rEn,
    input  logic [31:0] addr,
    output logic [31:0] rData,
    output logic        rxIrq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [31:0]   DATA_ADDR   = 32'hFFFF_FFF8;
    localparam logic [31:0]   STATUS_ADDR = 32'hFFFF_FFF4;
    localparam logic [CW-1:0] HALF_BIT    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_TICK   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;

    // ------------------------------------------------------------------
    // Input synchronizer; both flops reset to the idle line level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rxMeta, rxSync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM. START samples at mid start bit; from then on every
    // sample is a full bit period later, so DATA and STOP sample mid-bit
    // and STOP returns to IDLE half a bit early, leaving slack to catch a
    // back-to-back start edge.
    // ------------------------------------------------------------------
    rxState_e        state;
    logic [CW-1:0]   bitCnt;
    logic [2:0]      bitIdx;
    logic [7:0]      shiftReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxSync) begin
                        state  <= START;
                        bitCnt <= '0;
                    end
                end
                START: begin
                    if (bitCnt == HALF_BIT) begin
                        bitCnt <= '0;
                        if (!rxSync) begin
                            state  <= DATA;
                            bitIdx <= '0;
                        end else begin
                            state  <= IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bitCnt == LAST_TICK) begin
                        bitCnt           <= '0;
                        shiftReg[bitIdx] <= rxSync;
                        if (bitIdx == 3'd7) state  <= STOP;
                        else                bitIdx <= bitIdx + 3'd1;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bitCnt == LAST_TICK) begin
                        bitCnt <= '0;
                        state  <= IDLE;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    bitCnt <= '0;
                end
            endcase
        end
    end

    // Stop-bit sample strobes, decoded from registered FSM state so the
    // FIFO sees the byte on the same edge the stop bit is sampled.
    logic stopSample, pushReq, feSet;

    assign stopSample = (state == STOP) && (bitCnt == LAST_TICK);
    assign pushReq    = stopSample &&  rxSync;
    assign feSet      = stopSample && !rxSync;

    // ------------------------------------------------------------------
    // Receive FIFO and bus decode
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          nonEmpty, full;
    logic          isData, isStatus;
    logic          pop, wrAccept, ovrSet, flagClr;
    logic          ovr, fe;

    assign nonEmpty = (count != '0);
    assign full     = (count == DEPTH_CNT);
    assign isData   = (addr == DATA_ADDR);
    assign isStatus = (addr == STATUS_ADDR);

    assign pop      = rEn && isData && nonEmpty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wrAccept = pushReq && (!full || pop);
    assign ovrSet   = pushReq && full && !pop;
    assign flagClr  = rEn && isStatus;

    // When full, wrPtr == rdPtr; a simultaneous push/pop overwrites the
    // slot whose old contents are being popped on this same edge.
    always_ff @(posedge clk) begin
        if (wrAccept) mem[wrPtr] <= shiftReg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            ovr   <= 1'b0;
            fe    <= 1'b0;
            rxIrq <= 1'b0;
        end else begin
            if (wrAccept) wrPtr <= wrPtr + AW'(1);
            if (pop)      rdPtr <= rdPtr + AW'(1);
            case ({wrAccept, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A new error event beats a same-cycle clear.
            ovr   <= ovrSet | (ovr & !flagClr);
            fe    <= feSet  | (fe  & !flagClr);
            rxIrq <= nonEmpty;
        end
    end

    always_comb begin
        rData = 32'h0;
        if (isData && nonEmpty) rData = {24'b0, mem[rdPtr]};
        else if (isStatus)      rData = {28'b0, fe, ovr, full, nonEmpty};
    end

endmodule
